rmw_ooo_engine: RTL and testbench
=================================

RMW_OOO_ENGINE -- requirements
Module: rmw_ooo_engine

Interface
REQ-001 Parameters SHALL be: W, default 32, word width; N_ID, default 64, table entries; N_TAG, default 4, max outstanding lookups; SAT_EN, default 0, saturating ADDI/SUBI when 1.
REQ-002 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- iss_vld_r  in  1  issue valid.
- iss_id_r  in  clog2(N_ID)  target entry.
- iss_op_r  in  3  op_t.
- iss_imm_r  in  W  immediate.
- iss_rdy_w  out  1  issue ready, combinational.
- tbl_rd_r  out  1  lookup request.
- tbl_rd_id_r  out  clog2(N_ID)  lookup entry.
- tbl_rd_itag_r  out  clog2(N_TAG)  lookup tag.
- tbl_rd_word_vld_r  in  1  lookup return valid.
- tbl_rd_word_r  in  W  returned word.
- tbl_rd_ctag_r  in  clog2(N_TAG)  return tag.
- tbl_wr_r  out  1  writeback strobe.
- tbl_wr_id_r  out  clog2(N_ID)  writeback entry.
- tbl_wr_word_r  out  W  writeback word.
- cmpl_vld_r  out  1  completion valid.
- cmpl_id_r  out  clog2(N_ID)  completed entry.
- cmpl_word_r  out  W  result.
- inflight_r  out  clog2(N_TAG)+1  occupied tags.
- err_r  out  1  one-cycle pulse on bad return.

Function
REQ-003 An issue SHALL be accepted on a rising edge where iss_vld_r && iss_rdy_w.
REQ-004 iss_rdy_w SHALL be 1 iff at least one tag is free and no valid tag holds iss_id_r (same-ID hazard stall).
REQ-005 An accepted issue SHALL take the lowest-index free tag and store id, op and imm in it.
REQ-006 tbl_rd_r SHALL be high for exactly the cycle after acceptance, carrying tbl_rd_id_r=id and tbl_rd_itag_r=tag.
REQ-007 Returns SHALL be accepted in any order and at any latency of at least 1 cycle, with at most one return per cycle.
REQ-008 A return to a valid tag SHALL, in the next cycle, assert tbl_wr_r and cmpl_vld_r together with word=f(op,rd,imm), tbl_wr_id_r=cmpl_id_r=stored id, and SHALL free the tag in that same cycle.
REQ-009 Ops SHALL be: NOP=rd; ADDI=rd+imm; SUBI=rd-imm; MOVI=imm; ANDI=rd&imm; ORI=rd|imm; XORI=rd^imm; code 7 behaves as NOP.
REQ-010 Arithmetic with SAT_EN=0 SHALL be modulo 2^W; with SAT_EN=1 (unsigned), ADDI SHALL clamp at 2^W-1 and SUBI at 0.
REQ-011 A return whose tag is not valid SHALL be dropped, SHALL cause no write, and SHALL pulse err_r in the next cycle.
REQ-012 An acceptance and a return in the same cycle SHALL both take effect, and the tag freed in that cycle SHALL NOT be reallocated before the following cycle.
REQ-013 A same-ID issue presented in the cycle tbl_wr_r is high SHALL be accepted if a tag is free, so that its read follows the write.
REQ-014 inflight_r SHALL equal the count of valid tags, registered, and SHALL range from 0 to N_TAG.
REQ-015 With all N_TAG tags valid, iss_rdy_w SHALL be 0 regardless of iss_vld_r.

Reset
REQ-016 While rst_n=0, all tags SHALL be invalid and all outputs 0 except iss_rdy_w, which SHALL be 0.
REQ-017 Returns arriving during reset or within the first cycle after release SHALL be ignored without asserting err_r.
REQ-018 Reset asserted mid-operation SHALL discard in-flight ops, with no writeback or completion issued for them.

Structure
REQ-019 Package rmw_ooo_engine_pkg SHALL hold op_t (3-bit enum), the default parameter values, and width helper functions.
REQ-020 The op/saturation datapath SHALL be the combinational sub-module rmw_ooo_engine_alu, parameterised by W and SAT_EN.
REQ-021 Tag state SHALL be a flop array of N_TAG entries {vld, id, op, imm}, with no RAM.

Verification
REQ-022 ADDI id=5 imm=3, return rd=10 after 7 cycles -> one cycle later tbl_wr_r=1, id 5, word 13; cmpl_word_r=13.
REQ-023 Four issues to ids 1-4 -> tags 0-3 allocated, iss_rdy_w=0, inflight_r=4; return tag 2 -> next cycle rdy=1 and tag 2 reused.
REQ-024 Returns issued in order 3,0,2,1 -> completions arrive in order 3,0,2,1 with correct ids.
REQ-025 ADDI id=7 followed by SUBI id=7 -> second stalls until tbl_wr_r for 7, then tbl_rd_r occurs the cycle after.
REQ-026 SAT_EN=1, W=8: ADDI imm=20 on rd=250 -> 255; SUBI imm=9 on rd=4 -> 0.
REQ-027 Return on idle tag 1 -> err_r pulses once and tbl_wr_r stays 0; rst_n low with 2 in flight -> inflight_r=0 and no completions after release.

Source files
------------

// File: rtl/rmw_ooo_engine_pkg.sv
// Shared types, default sizes and width helpers for the out-of-order RMW engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rmw_ooo_engine_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADDI = 3'd1,
        OP_SUBI = 3'd2,
        OP_MOVI = 3'd3,
        OP_ANDI = 3'd4,
        OP_ORI  = 3'd5,
        OP_XORI = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    localparam int DEF_W      = 32;
    localparam int DEF_N_ID   = 64;
    localparam int DEF_N_TAG  = 4;
    localparam int DEF_SAT_EN = 0;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the value n itself.
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/rmw_ooo_engine_alu.sv
// Modify step of the read-modify-write: applies op to the returned word and immediate.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module rmw_ooo_engine_alu
    import rmw_ooo_engine_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int SAT_EN = DEF_SAT_EN
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] rd,
    input  logic [W-1:0] imm,
    output logic [W-1:0] res
);

    logic [W:0] sum;
    logic [W:0] dif;

    // One extra bit on add/sub exposes carry/borrow for unsigned clamping.
    always_comb begin
        sum = {1'b0, rd} + {1'b0, imm};
        dif = {1'b0, rd} - {1'b0, imm};
        res = rd;
        case (op_t'(op))
            OP_ADDI: res = (SAT_EN != 0 && sum[W]) ? {W{1'b1}} : sum[W-1:0];
            OP_SUBI: res = (SAT_EN != 0 && dif[W]) ? {W{1'b0}} : dif[W-1:0];
            OP_MOVI: res = imm;
            OP_ANDI: res = rd & imm;
            OP_ORI:  res = rd | imm;
            OP_XORI: res = rd ^ imm;
            default: res = rd;
        endcase
    end

endmodule

// File: rtl/rmw_ooo_engine.sv
// Out-of-order read-modify-write engine: tags lookups, applies op on return, writes back.
// Latency: lookup 1 cycle after accept; writeback/completion 1 cycle after return.
// Backpressure: iss_rdy_w drops when all tags are busy or the issued id is already in flight.
module rmw_ooo_engine
    import rmw_ooo_engine_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int N_ID   = DEF_N_ID,
    parameter int N_TAG  = DEF_N_TAG,
    parameter int SAT_EN = DEF_SAT_EN,
    localparam int IW    = idx_w(N_ID),
    localparam int TW    = idx_w(N_TAG),
    localparam int CW    = cnt_w(N_TAG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          iss_vld_r,
    input  logic [IW-1:0] iss_id_r,
    input  logic [2:0]    iss_op_r,
    input  logic [W-1:0]  iss_imm_r,
    output logic          iss_rdy_w,
    output logic          tbl_rd_r,
    output logic [IW-1:0] tbl_rd_id_r,
    output logic [TW-1:0] tbl_rd_itag_r,
    input  logic          tbl_rd_word_vld_r,
    input  logic [W-1:0]  tbl_rd_word_r,
    input  logic [TW-1:0] tbl_rd_ctag_r,
    output logic          tbl_wr_r,
    output logic [IW-1:0] tbl_wr_id_r,
    output logic [W-1:0]  tbl_wr_word_r,
    output logic          cmpl_vld_r,
    output logic [IW-1:0] cmpl_id_r,
    output logic [W-1:0]  cmpl_word_r,
    output logic [CW-1:0] inflight_r,
    output logic          err_r
);

    logic [N_TAG-1:0] tag_vld;
    logic [N_TAG-1:0] tag_vld_nxt;
    logic [IW-1:0]    tag_id  [N_TAG];
    logic [2:0]       tag_op  [N_TAG];
    logic [W-1:0]     tag_imm [N_TAG];

    // Low for the first edge after reset release so stale returns are ignored quietly.
    logic             alive;

    logic             any_free;
    logic             id_hit;
    logic [TW-1:0]    free_tag;
    logic             acc;
    logic             ret_hit;
    logic             ret_bad;
    logic [IW-1:0]    ret_id;
    logic [2:0]       ret_op;
    logic [W-1:0]     ret_imm;
    logic [W-1:0]     ret_res;
    logic [CW-1:0]    cnt_nxt;

    // Lowest free tag (descending scan, last write wins) and same-id hazard detect.
    always_comb begin
        any_free = 1'b0;
        id_hit   = 1'b0;
        free_tag = '0;
        for (int t = N_TAG - 1; t >= 0; t--) begin
            if (!tag_vld[t]) begin
                any_free = 1'b1;
                free_tag = TW'(t);
            end
            if (tag_vld[t] && tag_id[t] == iss_id_r) begin
                id_hit = 1'b1;
            end
        end
    end

    assign iss_rdy_w = alive && any_free && !id_hit;
    assign acc       = iss_vld_r && iss_rdy_w;

    // Match the return tag against live entries and pick out the stored op context.
    always_comb begin
        ret_hit = 1'b0;
        ret_id  = '0;
        ret_op  = '0;
        ret_imm = '0;
        for (int t = 0; t < N_TAG; t++) begin
            if (tbl_rd_ctag_r == TW'(t)) begin
                ret_hit = alive && tbl_rd_word_vld_r && tag_vld[t];
                ret_id  = tag_id[t];
                ret_op  = tag_op[t];
                ret_imm = tag_imm[t];
            end
        end
        ret_bad = alive && tbl_rd_word_vld_r && !ret_hit;
    end

    rmw_ooo_engine_alu #(
        .W      (W),
        .SAT_EN (SAT_EN)
    ) u_alu (
        .op  (ret_op),
        .rd  (tbl_rd_word_r),
        .imm (ret_imm),
        .res (ret_res)
    );

    // Next tag occupancy: a return frees its tag, an accept claims a different (currently free) one.
    always_comb begin
        tag_vld_nxt = tag_vld;
        cnt_nxt     = '0;
        for (int t = 0; t < N_TAG; t++) begin
            if (ret_hit && tbl_rd_ctag_r == TW'(t)) tag_vld_nxt[t] = 1'b0;
            if (acc && free_tag == TW'(t))          tag_vld_nxt[t] = 1'b1;
        end
        for (int t = 0; t < N_TAG; t++) begin
            cnt_nxt = cnt_nxt + CW'(tag_vld_nxt[t]);
        end
    end

    // Tag array: occupancy every cycle, op context captured on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int t = 0; t < N_TAG; t++) begin
                tag_id[t]  <= '0;
                tag_op[t]  <= '0;
                tag_imm[t] <= '0;
            end
        end else begin
            tag_vld <= tag_vld_nxt;
            if (acc) begin
                tag_id[free_tag]  <= iss_id_r;
                tag_op[free_tag]  <= iss_op_r;
                tag_imm[free_tag] <= iss_imm_r;
            end
        end
    end

    // Registered lookup, writeback, completion and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive         <= 1'b0;
            tbl_rd_r      <= 1'b0;
            tbl_rd_id_r   <= '0;
            tbl_rd_itag_r <= '0;
            tbl_wr_r      <= 1'b0;
            tbl_wr_id_r   <= '0;
            tbl_wr_word_r <= '0;
            cmpl_vld_r    <= 1'b0;
            cmpl_id_r     <= '0;
            cmpl_word_r   <= '0;
            inflight_r    <= '0;
            err_r         <= 1'b0;
        end else begin
            alive      <= 1'b1;
            tbl_rd_r   <= acc;
            tbl_wr_r   <= ret_hit;
            cmpl_vld_r <= ret_hit;
            err_r      <= ret_bad;
            inflight_r <= cnt_nxt;
            if (acc) begin
                tbl_rd_id_r   <= iss_id_r;
                tbl_rd_itag_r <= free_tag;
            end
            if (ret_hit) begin
                tbl_wr_id_r   <= ret_id;
                tbl_wr_word_r <= ret_res;
                cmpl_id_r     <= ret_id;
                cmpl_word_r   <= ret_res;
            end
        end
    end

endmodule

// File: tb/tb_rmw_ooo_engine.sv
// Scoreboard bench for rmw_ooo_engine: directed issues/returns, monitor checks writebacks.
// Latency: checks lookup one cycle after accept, writeback one cycle after return.
// Backpressure: exercises full-tag stall, same-id hazard and saturating variant.
module tb_rmw_ooo_engine;
    import rmw_ooo_engine_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main instance: W=32, N_ID=64, N_TAG=4, modulo arithmetic.
    logic        iss_vld = 1'b0;
    logic [5:0]  iss_id = '0;
    logic [2:0]  iss_op = '0;
    logic [31:0] iss_imm = '0;
    logic        iss_rdy;
    logic        tbl_rd;
    logic [5:0]  tbl_rd_id;
    logic [1:0]  tbl_rd_itag;
    logic        rvld = 1'b0;
    logic [31:0] rword = '0;
    logic [1:0]  rtag = '0;
    logic        tbl_wr;
    logic [5:0]  tbl_wr_id;
    logic [31:0] tbl_wr_word;
    logic        cmpl_vld;
    logic [5:0]  cmpl_id;
    logic [31:0] cmpl_word;
    logic [2:0]  inflight;
    logic        err;

    rmw_ooo_engine dut (
        .clk(clk), .rst_n(rst_n),
        .iss_vld_r(iss_vld), .iss_id_r(iss_id), .iss_op_r(iss_op), .iss_imm_r(iss_imm),
        .iss_rdy_w(iss_rdy),
        .tbl_rd_r(tbl_rd), .tbl_rd_id_r(tbl_rd_id), .tbl_rd_itag_r(tbl_rd_itag),
        .tbl_rd_word_vld_r(rvld), .tbl_rd_word_r(rword), .tbl_rd_ctag_r(rtag),
        .tbl_wr_r(tbl_wr), .tbl_wr_id_r(tbl_wr_id), .tbl_wr_word_r(tbl_wr_word),
        .cmpl_vld_r(cmpl_vld), .cmpl_id_r(cmpl_id), .cmpl_word_r(cmpl_word),
        .inflight_r(inflight), .err_r(err)
    );

    // Saturating instance: W=8, N_ID=16, N_TAG=2.
    logic        s_iss_vld = 1'b0;
    logic [3:0]  s_iss_id = '0;
    logic [2:0]  s_iss_op = '0;
    logic [7:0]  s_iss_imm = '0;
    logic        s_iss_rdy;
    logic        s_tbl_rd;
    logic [3:0]  s_tbl_rd_id;
    logic        s_tbl_rd_itag;
    logic        s_rvld = 1'b0;
    logic [7:0]  s_rword = '0;
    logic        s_rtag = 1'b0;
    logic        s_tbl_wr;
    logic [3:0]  s_tbl_wr_id;
    logic [7:0]  s_tbl_wr_word;
    logic        s_cmpl_vld;
    logic [3:0]  s_cmpl_id;
    logic [7:0]  s_cmpl_word;
    logic [1:0]  s_inflight;
    logic        s_err;

    rmw_ooo_engine #(.W(8), .N_ID(16), .N_TAG(2), .SAT_EN(1)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .iss_vld_r(s_iss_vld), .iss_id_r(s_iss_id), .iss_op_r(s_iss_op), .iss_imm_r(s_iss_imm),
        .iss_rdy_w(s_iss_rdy),
        .tbl_rd_r(s_tbl_rd), .tbl_rd_id_r(s_tbl_rd_id), .tbl_rd_itag_r(s_tbl_rd_itag),
        .tbl_rd_word_vld_r(s_rvld), .tbl_rd_word_r(s_rword), .tbl_rd_ctag_r(s_rtag),
        .tbl_wr_r(s_tbl_wr), .tbl_wr_id_r(s_tbl_wr_id), .tbl_wr_word_r(s_tbl_wr_word),
        .cmpl_vld_r(s_cmpl_vld), .cmpl_id_r(s_cmpl_id), .cmpl_word_r(s_cmpl_word),
        .inflight_r(s_inflight), .err_r(s_err)
    );

    typedef struct {
        logic [5:0]  id;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every writeback/completion must match the oldest expected entry.
    always @(negedge clk) begin
        if (tbl_wr || cmpl_vld) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", {63'd0, tbl_wr}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_wr", {63'd0, tbl_wr}, 64'd1);
                chk("wb_cmpl", {63'd0, cmpl_vld}, 64'd1);
                chk("wb_id", {58'd0, tbl_wr_id}, {58'd0, e.id});
                chk("wb_word", {32'd0, tbl_wr_word}, {32'd0, e.word});
                chk("cmpl_id", {58'd0, cmpl_id}, {58'd0, e.id});
                chk("cmpl_word", {32'd0, cmpl_word}, {32'd0, e.word});
            end
        end
    end

    task automatic do_issue(input logic [5:0] id, input logic [2:0] op, input logic [31:0] imm,
                            input logic [1:0] exp_tag);
        @(negedge clk);
        iss_vld = 1'b1; iss_id = id; iss_op = op; iss_imm = imm;
        #1 chk("iss_rdy", {63'd0, iss_rdy}, 64'd1);
        @(negedge clk);
        iss_vld = 1'b0;
        chk("rd_strobe", {63'd0, tbl_rd}, 64'd1);
        chk("rd_id", {58'd0, tbl_rd_id}, {58'd0, id});
        chk("rd_tag", {62'd0, tbl_rd_itag}, {62'd0, exp_tag});
    endtask

    task automatic do_return(input logic [1:0] tag, input logic [31:0] rd,
                             input logic [5:0] exp_id, input logic [31:0] exp_word);
        exp_t e;
        @(negedge clk);
        rvld = 1'b1; rtag = tag; rword = rd;
        e.id = exp_id; e.word = exp_word;
        sb.push_back(e);
        @(negedge clk);
        rvld = 1'b0;
    endtask

    task automatic s_issue(input logic [3:0] id, input logic [2:0] op, input logic [7:0] imm);
        @(negedge clk);
        s_iss_vld = 1'b1; s_iss_id = id; s_iss_op = op; s_iss_imm = imm;
        #1 chk("s_iss_rdy", {63'd0, s_iss_rdy}, 64'd1);
        @(negedge clk);
        s_iss_vld = 1'b0;
        chk("s_rd_strobe", {63'd0, s_tbl_rd}, 64'd1);
    endtask

    task automatic s_return(input logic tag, input logic [7:0] rd, input logic [7:0] exp_word);
        @(negedge clk);
        s_rvld = 1'b1; s_rtag = tag; s_rword = rd;
        @(negedge clk);
        s_rvld = 1'b0;
        chk("s_wr", {63'd0, s_tbl_wr}, 64'd1);
        chk("s_wr_word", {56'd0, s_tbl_wr_word}, {56'd0, exp_word});
        chk("s_cmpl_word", {56'd0, s_cmpl_word}, {56'd0, exp_word});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with a stray return held across reset and the first edge after release.
        rvld = 1'b1; rtag = 2'd0; rword = 32'h1;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {63'd0, iss_rdy}, 64'd0);
        chk("rst_rd", {63'd0, tbl_rd}, 64'd0);
        chk("rst_wr", {63'd0, tbl_wr}, 64'd0);
        chk("rst_inflight", {61'd0, inflight}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rvld = 1'b0;
        chk("post_rst_err", {63'd0, err}, 64'd0);
        @(negedge clk);
        chk("post_rst_err2", {63'd0, err}, 64'd0);
        chk("post_rst_rdy", {63'd0, iss_rdy}, 64'd1);

        // ADDI id 5 imm 3, return 10 several cycles later -> 13.
        do_issue(6'd5, OP_ADDI, 32'd3, 2'd0);
        chk("inflight_1", {61'd0, inflight}, 64'd1);
        repeat (6) @(negedge clk);
        do_return(2'd0, 32'd10, 6'd5, 32'd13);
        chk("inflight_0", {61'd0, inflight}, 64'd0);

        // Fill all four tags.
        do_issue(6'd1, OP_MOVI, 32'h55, 2'd0);
        do_issue(6'd2, OP_ANDI, 32'hF0, 2'd1);
        do_issue(6'd3, OP_ORI,  32'h0F, 2'd2);
        do_issue(6'd4, OP_XORI, 32'hFF, 2'd3);
        @(negedge clk);
        iss_vld = 1'b1; iss_id = 6'd10; iss_op = OP_NOP; iss_imm = '0;
        #1 chk("full_rdy", {63'd0, iss_rdy}, 64'd0);
        chk("full_inflight", {61'd0, inflight}, 64'd4);
        iss_vld = 1'b0;

        // Free tag 2, then it is reused by the next issue.
        do_return(2'd2, 32'hA0, 6'd3, 32'hAF);
        do_issue(6'd9, OP_NOP, 32'd0, 2'd2);

        // Out-of-order returns 3,0,2,1.
        do_return(2'd3, 32'h0F, 6'd4, 32'hF0);
        do_return(2'd0, 32'h1234, 6'd1, 32'h55);
        do_return(2'd2, 32'hDEADBEEF, 6'd9, 32'hDEADBEEF);
        do_return(2'd1, 32'h3C, 6'd2, 32'h30);
        chk("ooo_inflight", {61'd0, inflight}, 64'd0);

        // Accept and return in the same cycle; modulo wrap both ways.
        do_issue(6'd20, OP_ADDI, 32'hFFFFFFFF, 2'd0);
        begin
            exp_t e;
            @(negedge clk);
            iss_vld = 1'b1; iss_id = 6'd21; iss_op = OP_SUBI; iss_imm = 32'd1;
            rvld = 1'b1; rtag = 2'd0; rword = 32'd1;
            e.id = 6'd20; e.word = 32'd0;
            sb.push_back(e);
            #1 chk("same_cyc_rdy", {63'd0, iss_rdy}, 64'd1);
            @(negedge clk);
            iss_vld = 1'b0; rvld = 1'b0;
            chk("same_cyc_rd", {63'd0, tbl_rd}, 64'd1);
            chk("same_cyc_tag", {62'd0, tbl_rd_itag}, 64'd1);
            chk("same_cyc_id", {58'd0, tbl_rd_id}, 64'd21);
            chk("same_cyc_inflight", {61'd0, inflight}, 64'd1);
        end
        do_return(2'd1, 32'd0, 6'd21, 32'hFFFFFFFF);

        // Same-id hazard: SUBI id 7 waits for the ADDI id 7 writeback.
        do_issue(6'd7, OP_ADDI, 32'd1, 2'd0);
        begin
            exp_t e;
            @(negedge clk);
            iss_vld = 1'b1; iss_id = 6'd7; iss_op = OP_SUBI; iss_imm = 32'd2;
            #1 chk("haz_rdy_a", {63'd0, iss_rdy}, 64'd0);
            @(negedge clk);
            #1 chk("haz_rdy_b", {63'd0, iss_rdy}, 64'd0);
            @(negedge clk);
            rvld = 1'b1; rtag = 2'd0; rword = 32'd100;
            e.id = 6'd7; e.word = 32'd101;
            sb.push_back(e);
            #1 chk("haz_rdy_c", {63'd0, iss_rdy}, 64'd0);
            @(negedge clk);
            rvld = 1'b0;
            #1 chk("haz_wr", {63'd0, tbl_wr}, 64'd1);
            chk("haz_rdy_wr", {63'd0, iss_rdy}, 64'd1);
            chk("haz_no_rd", {63'd0, tbl_rd}, 64'd0);
            @(negedge clk);
            iss_vld = 1'b0;
            chk("haz_rd", {63'd0, tbl_rd}, 64'd1);
            chk("haz_rd_id", {58'd0, tbl_rd_id}, 64'd7);
            chk("haz_rd_tag", {62'd0, tbl_rd_itag}, 64'd0);
        end
        do_return(2'd0, 32'd50, 6'd7, 32'd48);

        // Return to an idle tag: one err pulse, no write.
        @(negedge clk);
        rvld = 1'b1; rtag = 2'd1; rword = 32'h77;
        @(negedge clk);
        rvld = 1'b0;
        chk("bad_err", {63'd0, err}, 64'd1);
        chk("bad_wr", {63'd0, tbl_wr}, 64'd0);
        @(negedge clk);
        chk("bad_err_once", {63'd0, err}, 64'd0);

        // Reset with two in flight: discarded, nothing completes afterwards.
        do_issue(6'd30, OP_ADDI, 32'd1, 2'd0);
        do_issue(6'd31, OP_ADDI, 32'd2, 2'd1);
        chk("pre_rst_inflight", {61'd0, inflight}, 64'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("mid_rst_inflight", {61'd0, inflight}, 64'd0);
        chk("mid_rst_rdy", {63'd0, iss_rdy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("after_rst_inflight", {61'd0, inflight}, 64'd0);

        // Saturating 8-bit variant.
        s_issue(4'd3, OP_ADDI, 8'd20);
        s_return(1'b0, 8'd250, 8'd255);
        s_issue(4'd3, OP_SUBI, 8'd9);
        s_return(1'b0, 8'd4, 8'd0);
        s_issue(4'd5, OP_ADDI, 8'd4);
        s_return(1'b0, 8'd250, 8'd254);

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
